// File: rtl/core_overlap_stream.sv
// Streaming overlap-add of N_CORES core output columns per beat. The tail that
// overlaps the next beat is carried forward, and a flush beat drains it on last.
module core_overlap_stream #(
   parameter int N_CORES                 = 4,
   parameter int SIZE_OF_EACH_CORE_INPUT = 2,
   parameter int SIZE_OF_EACH_KERNEL     = 3,
   parameter int STRIDE                  = 1,
   parameter int PIX_WIDTH               = 8,
   parameter int OUT_WIDTH               = 10,
   parameter int SATURATE                = 1,
   localparam int NOV  = SIZE_OF_EACH_CORE_INPUT * STRIDE,
   localparam int PIN  = STRIDE * (SIZE_OF_EACH_CORE_INPUT - 1) + SIZE_OF_EACH_KERNEL,
   localparam int OVL  = PIN - NOV,
   localparam int POUT = NOV * N_CORES
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic                          last_i,
   input  logic [N_CORES*PIN*PIX_WIDTH-1:0] core_data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          last_o,
   output logic [POUT*OUT_WIDTH-1:0]     overlapped_column_o,
   output logic                          sat_o
);

   localparam int SPAN = POUT + OVL;
   localparam int SW   = PIX_WIDTH + $clog2(N_CORES * PIN);
   // One spare bit so the head sum plus carry can never wrap.
   localparam int AW   = SW + 1;
   localparam int XW   = (AW > OUT_WIDTH) ? AW : OUT_WIDTH;
   localparam logic [XW-1:0] MAXV = (XW'(1) << OUT_WIDTH) - XW'(1);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

   state_e                      state_q, state_d;
   logic                        valid_q, valid_d;
   logic                        last_q, last_d;
   logic                        sat_q, sat_d;
   logic [POUT*OUT_WIDTH-1:0]   col_q, col_d;
   logic [AW-1:0]               carry_q [OVL];
   logic [AW-1:0]               carry_d [OVL];
   logic [AW-1:0]               span [SPAN];
   logic [OUT_WIDTH:0]          beat_px [POUT];
   logic [OUT_WIDTH:0]          flush_px [OVL];
   logic                        free;
   logic                        accept;

   // Returns {clipped, pixel}.
   function automatic logic [OUT_WIDTH:0] clip_or_wrap(input logic [AW-1:0] v);
      logic [XW-1:0] x;
      x = XW'(v);
      if ((SATURATE != 0) && (x > MAXV)) return {1'b1, MAXV[OUT_WIDTH-1:0]};
      return {1'b0, x[OUT_WIDTH-1:0]};
   endfunction

   assign free    = !valid_q || ready_i;
   assign ready_o = (state_q == ST_RUN) && en_i && free;
   assign accept  = valid_i && ready_o;

   always_comb begin
      for (int p = 0; p < SPAN; p++) span[p] = '0;
      for (int k = 0; k < N_CORES; k++) begin
         for (int i = 0; i < PIN; i++) begin
            span[k*NOV+i] = span[k*NOV+i]
                          + AW'(core_data_i[(k*PIN+i)*PIX_WIDTH +: PIX_WIDTH]);
         end
      end
      for (int p = 0; p < OVL; p++) span[p] = span[p] + carry_q[p];
   end

   always_comb begin
      for (int j = 0; j < POUT; j++) beat_px[j] = clip_or_wrap(span[j]);
      for (int q = 0; q < OVL; q++) flush_px[q] = clip_or_wrap(carry_q[q]);
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q && !ready_i;
      last_d  = last_q;
      sat_d   = sat_q;
      col_d   = col_q;
      carry_d = carry_q;
      case (state_q)
         ST_RUN: begin
            if (accept) begin
               valid_d = 1'b1;
               last_d  = 1'b0;
               sat_d   = 1'b0;
               for (int j = 0; j < POUT; j++) begin
                  col_d[j*OUT_WIDTH +: OUT_WIDTH] = beat_px[j][OUT_WIDTH-1:0];
                  sat_d = sat_d | beat_px[j][OUT_WIDTH];
               end
               for (int q = 0; q < OVL; q++) carry_d[q] = span[POUT+q];
               if (last_i) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (en_i && free) begin
               valid_d = 1'b1;
               last_d  = 1'b1;
               sat_d   = 1'b0;
               col_d   = '0;
               for (int q = 0; q < OVL; q++) begin
                  col_d[q*OUT_WIDTH +: OUT_WIDTH] = flush_px[q][OUT_WIDTH-1:0];
                  sat_d      = sat_d | flush_px[q][OUT_WIDTH];
                  carry_d[q] = '0;
               end
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sat_q   <= 1'b0;
         col_q   <= '0;
         for (int q = 0; q < OVL; q++) carry_q[q] <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         sat_q   <= sat_d;
         col_q   <= col_d;
         for (int q = 0; q < OVL; q++) carry_q[q] <= carry_d[q];
      end
   end

   assign valid_o             = valid_q;
   assign last_o              = last_q;
   assign sat_o               = sat_q;
   assign overlapped_column_o = col_q;

endmodule

// File: tb/tb_core_overlap_stream.sv
// Self-checking bench for core_overlap_stream: directed scenarios with inline
// checks plus a scoreboard of every output beat fed from a reference model.
`timescale 1ns/1ps
module tb_core_overlap_stream;

   localparam int NC = 4, PIN = 4, NOV = 2, OVL = 2, POUT = 8, SPAN = 10;
   localparam int PW = 8, OW = 10, MAXV = 1023;
   localparam int DW = NC*PIN*PW, OCW = POUT*OW, EW = OCW + 2;

   logic clk = 1'b0;
   logic rst_i, en_i, valid_i, last_i, ready_i;
   logic [DW-1:0] core_data_i;
   logic ready_o, valid_o, last_o, sat_o;
   logic [OCW-1:0] overlapped_column_o;
   logic s8_ready, s8_valid, s8_last, s8_sat;
   logic w8_ready, w8_valid, w8_last, w8_sat;
   logic [POUT*8-1:0] s8_col, w8_col;

   int tests_run = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];
   int mcarry[OVL];

   always #5 clk = ~clk;

   core_overlap_stream #(.OUT_WIDTH(10), .SATURATE(1)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(ready_o),
      .last_i(last_i), .core_data_i(core_data_i), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .overlapped_column_o(overlapped_column_o), .sat_o(sat_o));

   core_overlap_stream #(.OUT_WIDTH(8), .SATURATE(1)) dut_s8 (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(s8_ready),
      .last_i(last_i), .core_data_i(core_data_i), .valid_o(s8_valid), .ready_i(ready_i),
      .last_o(s8_last), .overlapped_column_o(s8_col), .sat_o(s8_sat));

   core_overlap_stream #(.OUT_WIDTH(8), .SATURATE(0)) dut_w8 (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(w8_ready),
      .last_i(last_i), .core_data_i(core_data_i), .valid_o(w8_valid), .ready_i(ready_i),
      .last_o(w8_last), .overlapped_column_o(w8_col), .sat_o(w8_sat));

   function automatic logic [DW-1:0] fill(input int v);
      logic [DW-1:0] d;
      for (int n = 0; n < NC*PIN; n++) d[n*PW +: PW] = PW'(v);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] d;
      for (int n = 0; n < NC*PIN; n++) d[n*PW +: PW] = PW'($urandom_range(0, 255));
      return d;
   endfunction

   function automatic logic [OCW-1:0] pack_col(input int e[POUT]);
      logic [OCW-1:0] c;
      for (int j = 0; j < POUT; j++) c[j*OW +: OW] = OW'(e[j]);
      return c;
   endfunction

   // Reference model: overlap-add of one accepted beat, plus its flush if last.
   task automatic model_accept(input logic [DW-1:0] d, input logic l);
      int sp[SPAN];
      logic [EW-1:0] e;
      bit s;
      for (int p = 0; p < SPAN; p++) sp[p] = 0;
      for (int k = 0; k < NC; k++)
         for (int i = 0; i < PIN; i++) sp[k*NOV+i] += int'(d[(k*PIN+i)*PW +: PW]);
      for (int p = 0; p < OVL; p++) sp[p] += mcarry[p];
      e = '0; s = 0;
      for (int j = 0; j < POUT; j++) begin
         if (sp[j] > MAXV) begin s = 1; e[j*OW +: OW] = OW'(MAXV); end
         else e[j*OW +: OW] = OW'(sp[j]);
      end
      e[OCW] = 1'b0; e[OCW+1] = s;
      exp_q.push_back(e);
      for (int q = 0; q < OVL; q++) mcarry[q] = sp[POUT+q];
      if (l) begin
         e = '0; s = 0;
         for (int q = 0; q < OVL; q++) begin
            if (mcarry[q] > MAXV) begin s = 1; e[q*OW +: OW] = OW'(MAXV); end
            else e[q*OW +: OW] = OW'(mcarry[q]);
            mcarry[q] = 0;
         end
         e[OCW] = 1'b1; e[OCW+1] = s;
         exp_q.push_back(e);
      end
   endtask

   // Presents a beat and returns at posedge+1 after it is accepted; valid_i stays high.
   task automatic send_beat(input logic [DW-1:0] d, input logic l, output int waited);
      bit done;
      valid_i = 1'b1; core_data_i = d; last_i = l; waited = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (ready_o) begin
            model_accept(d, l);
            @(posedge clk); #1;
            done = 1;
         end else begin
            waited++;
            if (waited > 50) begin
               tests_run++; tests_failed++;
               $display("FAIL send_timeout: ready_o stayed %b, required 1", ready_o);
               valid_i = 1'b0;
               done = 1;
            end
         end
      end
   endtask

   task automatic test_reset();
      #3;
      tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b need 0", valid_o); end
      tests_run++; if (last_o !== 1'b0) begin tests_failed++; $display("FAIL rst_last: got %b need 0", last_o); end
      tests_run++; if (sat_o !== 1'b0) begin tests_failed++; $display("FAIL rst_sat: got %b need 0", sat_o); end
      tests_run++; if (overlapped_column_o !== '0) begin tests_failed++; $display("FAIL rst_col: got %h need 0", overlapped_column_o); end
      @(posedge clk); #1; rst_i = 1'b0;
      @(negedge clk);
      tests_run++; if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b need 1", ready_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat();
      int w;
      int e0[POUT], ef[POUT];
      e0 = '{1, 1, 2, 2, 2, 2, 2, 2};
      ef = '{1, 1, 0, 0, 0, 0, 0, 0};
      send_beat(fill(1), 1'b1, w);
      valid_i = 1'b0; last_i = 1'b0;
      tests_run++; if (overlapped_column_o !== pack_col(e0) || last_o !== 1'b0 || valid_o !== 1'b1) begin
         tests_failed++; $display("FAIL single_beat0: got col=%h last=%b valid=%b need col=%h last=0 valid=1", overlapped_column_o, last_o, valid_o, pack_col(e0)); end
      @(posedge clk); #1;
      tests_run++; if (overlapped_column_o !== pack_col(ef) || last_o !== 1'b1 || valid_o !== 1'b1) begin
         tests_failed++; $display("FAIL single_flush: got col=%h last=%b valid=%b need col=%h last=1 valid=1", overlapped_column_o, last_o, valid_o, pack_col(ef)); end
      @(posedge clk); #1;
      tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_count: valid_o=%b after flush, need 0", valid_o); end
   endtask

   task automatic test_two_beats();
      int w;
      int e0[POUT], e1[POUT], ef[POUT];
      e0 = '{1, 1, 2, 2, 2, 2, 2, 2};
      e1 = '{2, 2, 2, 2, 2, 2, 2, 2};
      ef = '{1, 1, 0, 0, 0, 0, 0, 0};
      send_beat(fill(1), 1'b0, w);
      tests_run++; if (overlapped_column_o !== pack_col(e0)) begin tests_failed++; $display("FAIL two_beat0: got %h need %h", overlapped_column_o, pack_col(e0)); end
      send_beat(fill(1), 1'b1, w);
      valid_i = 1'b0; last_i = 1'b0;
      tests_run++; if (overlapped_column_o !== pack_col(e1) || last_o !== 1'b0) begin tests_failed++; $display("FAIL two_beat1: got %h last=%b need %h last=0", overlapped_column_o, last_o, pack_col(e1)); end
      @(posedge clk); #1;
      tests_run++; if (overlapped_column_o !== pack_col(ef) || last_o !== 1'b1) begin tests_failed++; $display("FAIL two_flush: got %h last=%b need %h last=1", overlapped_column_o, last_o, pack_col(ef)); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      int w;
      send_beat(fill(255), 1'b1, w);
      valid_i = 1'b0; last_i = 1'b0;
      tests_run++; if (s8_col[2*8 +: 8] !== 8'hFF || s8_sat !== 1'b1) begin tests_failed++; $display("FAIL sat_clip: got px2=%h sat=%b need ff sat=1", s8_col[2*8 +: 8], s8_sat); end
      tests_run++; if (w8_col[2*8 +: 8] !== 8'hFE || w8_sat !== 1'b0) begin tests_failed++; $display("FAIL sat_wrap: got px2=%h sat=%b need fe sat=0", w8_col[2*8 +: 8], w8_sat); end
      tests_run++; if (overlapped_column_o[2*OW +: OW] !== 10'd510 || sat_o !== 1'b0) begin tests_failed++; $display("FAIL sat_wide: got px2=%0d sat=%b need 510 sat=0", overlapped_column_o[2*OW +: OW], sat_o); end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_backpressure();
      int w;
      logic [DW-1:0] b;
      logic [OCW-1:0] held_col;
      logic held_last;
      ready_i = 1'b0;
      send_beat(rand_beat(), 1'b0, w);
      held_col = overlapped_column_o; held_last = last_o;
      b = rand_beat();
      core_data_i = b; last_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || overlapped_column_o !== held_col || last_o !== held_last) begin
            tests_failed++; $display("FAIL bp_hold: cycle %0d valid=%b ready=%b col=%h last=%b need valid=1 ready=0 col=%h last=%b", c, valid_o, ready_o, overlapped_column_o, last_o, held_col, held_last); end
      end
      @(posedge clk); #1; ready_i = 1'b1;
      send_beat(b, 1'b0, w);
      tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL bp_resume: waited %0d need 0", w); end
      send_beat(rand_beat(), 1'b1, w);
      tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL bp_stream: waited %0d need 0", w); end
      valid_i = 1'b0; last_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_back_to_back();
      int w;
      for (int n = 0; n < 6; n++) begin
         send_beat(rand_beat(), (n == 5), w);
         tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL b2b_rate: beat %0d waited %0d need 0", n, w); end
      end
      valid_i = 1'b0; last_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_async_reset();
      int w;
      int e0[POUT];
      e0 = '{1, 1, 2, 2, 2, 2, 2, 2};
      send_beat(fill(1), 1'b0, w);
      valid_i = 1'b0;
      #2; rst_i = 1'b1; #1;
      tests_run++; if (valid_o !== 1'b0 || overlapped_column_o !== '0) begin tests_failed++; $display("FAIL arst_drop: got valid=%b col=%h need 0 0", valid_o, overlapped_column_o); end
      exp_q.delete();
      for (int q = 0; q < OVL; q++) mcarry[q] = 0;
      @(posedge clk); #1; rst_i = 1'b0;
      send_beat(fill(1), 1'b1, w);
      valid_i = 1'b0; last_i = 1'b0;
      tests_run++; if (overlapped_column_o !== pack_col(e0)) begin tests_failed++; $display("FAIL arst_stale: got %h need %h", overlapped_column_o, pack_col(e0)); end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_enable_flush();
      int w;
      send_beat(fill(3), 1'b1, w);
      valid_i = 1'b0; last_i = 1'b0;
      en_i = 1'b0;
      @(negedge clk);
      tests_run++; if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL en_ready: got %b need 0", ready_o); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests_run++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin tests_failed++; $display("FAIL en_noflush: cycle %0d valid=%b ready=%b need 0 0", c, valid_o, ready_o); end
      end
      @(posedge clk); #1; en_i = 1'b1;
      @(negedge clk);
      tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL en_early: valid=%b need 0", valid_o); end
      @(posedge clk); #1;
      tests_run++; if (valid_o !== 1'b1 || last_o !== 1'b1) begin tests_failed++; $display("FAIL en_flush: valid=%b last=%b need 1 1", valid_o, last_o); end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [EW-1:0] e;
      rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
      core_data_i = '0;
      for (int q = 0; q < OVL; q++) mcarry[q] = 0;
      fork
         forever begin
            @(negedge clk);
            if (!rst_i && valid_o && ready_i) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  tests_failed++; $display("FAIL sb_extra: unexpected beat col=%h last=%b", overlapped_column_o, last_o);
               end else begin
                  e = exp_q.pop_front();
                  if ({sat_o, last_o, overlapped_column_o} !== e) begin
                     tests_failed++; $display("FAIL sb_beat: got %h need %h", {sat_o, last_o, overlapped_column_o}, e); end
               end
            end
         end
      join_none
      test_reset();
      test_single_beat();
      test_two_beats();
      test_saturate();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_enable_flush();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sb_drain: %0d beats missing, need 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
